uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Downstream stage of the UART receiver, clocked on the same baud clock. Watches the receiver's data byte and busy flag, qualifies each completed frame by its busy-high duration, and rejects frames with a bad stop bit. Pushes accepted bytes into a first-word-fall-through FIFO drained by a valid/ready consumer. Keeps a sticky overflow flag and a saturating frame-error counter.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
ADDR_W, 4, log2(DEPTH); derived localparam, not overridable
FRAME_CYCLES, 9, baud_clk cycles rx_busy stays high for a good frame (8 data + 1 stop)

Ports:
baud_clk  in  1  baud clock shared with the receiver; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  receiver byte output; valid in the cycle rx_busy falls after a good frame
rx_busy  in  1  receiver busy flag
out_data  out  8  FIFO head byte; meaningful only when out_valid=1
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer pops head when out_valid & out_ready
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: an accepted byte was dropped because the FIFO was full
clr_overflow  in  1  synchronous clear of overflow
err_count  out  8  saturating count of rejected frames

Behaviour:
- Reset (rst_n=0, async): count=0, pointers=0, out_valid=0, overflow=0, err_count=0, busy_q=0, run=0, armed=0. out_data is don't-care.
- Frame monitor: busy_q is rx_busy registered. rise = ~busy_q & rx_busy. fall = busy_q & ~rx_busy.
- On rise: armed<=1, run<=1.
- While busy_q & rx_busy: run increments, saturating at 15 (4-bit).
- On fall with armed=1:
  - run==FRAME_CYCLES: good frame; push rx_data as sampled in this same cycle.
  - Otherwise: reject; err_count increments, saturating at 255.
  - Both cases: armed<=0.
- On fall with armed=0 (busy already high when reset released): discard silently; no push, no error count.
- A failed-stop frame holds rx_busy high FRAME_CYCLES+1 cycles, so it is rejected.
- FIFO is FWFT:
  - out_valid = (count!=0).
  - out_data = mem[rd_ptr], combinational read of the head.
  - Push-to-out_valid latency is 1 cycle, so a byte pushed at edge N is visible after edge N.
- Pointers are ADDR_W bits and wrap naturally at DEPTH.
- Push only: if count<DEPTH, write mem[wr_ptr], wr_ptr+1, count+1. If count==DEPTH, drop the byte and set overflow.
- Pop only (out_valid & out_ready): rd_ptr+1, count-1. out_ready while empty is ignored.
- Simultaneous push and pop:
  - Non-empty: both happen and count is unchanged. This holds when full as well; no overflow, because the pop frees the slot.
  - Empty: the push happens and the pop is ignored, since out_valid=0 that cycle.
- overflow: set has priority over clr_overflow in the same cycle.
- Reset mid-frame: all state clears and armed=0, so the partial frame is discarded per the unarmed rule.

Decomposition:
- Shared uart package holds:
  - FRAME_CYCLES default
  - data width constant (8)
  - err_count width (8)
- One natural sub-module: sync_fifo_fwft (storage, pointers, count, overflow).
- uart_rx_fifo holds the frame monitor and instantiates sync_fifo_fwft.

Test Plan:
- Reset, then drive rx_busy high 9 cycles with rx_data=8'hA5 at the fall -> next cycle out_valid=1, out_data=A5, count=1, err_count=0.
- Drive rx_busy high 10 cycles with rx_data=8'h3C -> no push, count unchanged, err_count increments by 1.
- Push 16 good frames 0x00..0x0F with out_ready=0, then a 17th 0xFF -> count=16, overflow=1. Then drain with out_ready=1 -> 0x00..0x0F in order, out_valid=0 after the 16th pop.
- With the FIFO full, a good frame falls in the same cycle as a pop -> count stays 16, overflow stays 0, new byte appears last.
- Assert rst_n=0 for 1 cycle while rx_busy is high mid-frame -> all outputs cleared; the following fall is neither pushed nor counted. The next full good frame 8'h5A is accepted.
- Inject 260 bad frames -> err_count saturates at 255. Assert clr_overflow and a dropping push in the same cycle -> overflow remains 1.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and helpers for the UART receive-side FIFO stage.
// Widths here are fixed by the receiver byte format and the error counter size.
package uart_rx_fifo_pkg;

    localparam int DATA_W           = 8;
    localparam int ERR_W            = 8;
    localparam int RUN_W            = 4;
    localparam int FRAME_CYCLES_DEF = 9;

    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
        logic [ERR_W-1:0] r;
        if (v == {ERR_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + ERR_W'(1);
        end
        return r;
    endfunction

    function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] v);
        logic [RUN_W-1:0] r;
        if (v == {RUN_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + RUN_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Valid/ready consumer port of the receive FIFO.
// The master side presents the FWFT head byte; the slave side pops it.
interface uart_rx_fifo_if;
    import uart_rx_fifo_pkg::*;

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/uart_rx_fifo_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with a sticky overflow flag.
// A push while full is dropped unless a pop frees the slot in that same cycle.
module sync_fifo_fwft #(
    parameter  int DEPTH  = 16,
    parameter  int WIDTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [WIDTH-1:0]  push_data_i,
    input  logic              pop_i,
    input  logic              clr_overflow_i,
    output logic [WIDTH-1:0]  rd_data_o,
    output logic              valid_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              full_s, pop_s, wr_en_s;

    assign full_s  = (count_q == (ADDR_W+1)'(DEPTH));
    assign pop_s   = pop_i & (count_q != '0);
    assign wr_en_s = push_i & (~full_s | pop_s);

    // Next-state for pointers, occupancy and overflow
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
        if (push_i & ~wr_en_s) begin
            overflow_d = 1'b1;
        end else if (clr_overflow_i) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign rd_data_o  = mem_q[rd_ptr_q];
    assign valid_o    = (count_q != '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Frame monitor on the receiver busy flag: accepts frames whose busy pulse is
// exactly FRAME_CYCLES long, counts rejects, and queues accepted bytes.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter  int DEPTH        = 16,
    parameter  int FRAME_CYCLES = FRAME_CYCLES_DEF,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic               baud_clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  rx_data,
    input  logic               rx_busy,
    uart_rx_fifo_if.master     out_if,
    output logic [ADDR_W:0]    count,
    output logic               overflow,
    input  logic               clr_overflow,
    output logic [ERR_W-1:0]   err_count
);

    logic             busy_q;
    logic [RUN_W-1:0] run_q, run_d;
    logic             armed_q, armed_d;
    logic             idle_seen_q, idle_seen_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             rise_s, fall_s, push_s;

    assign rise_s = ~busy_q & rx_busy;
    assign fall_s = busy_q & ~rx_busy;

    // Frame qualification; a pulse already high at reset release never arms
    always_comb begin
        run_d       = run_q;
        armed_d     = armed_q;
        err_d       = err_q;
        push_s      = 1'b0;
        idle_seen_d = idle_seen_q | ~rx_busy;
        if (rise_s) begin
            armed_d = idle_seen_q;
            run_d   = RUN_W'(1);
        end else if (busy_q & rx_busy) begin
            run_d = run_sat_inc(run_q);
        end else if (fall_s & armed_q) begin
            armed_d = 1'b0;
            if (run_q == RUN_W'(FRAME_CYCLES)) begin
                push_s = 1'b1;
            end else begin
                err_d = err_sat_inc(err_q);
            end
        end else begin
            armed_d = armed_q;
        end
    end

    // Monitor state register
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            run_q       <= '0;
            armed_q     <= 1'b0;
            idle_seen_q <= 1'b0;
            err_q       <= '0;
        end else begin
            busy_q      <= rx_busy;
            run_q       <= run_d;
            armed_q     <= armed_d;
            idle_seen_q <= idle_seen_d;
            err_q       <= err_d;
        end
    end

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk            (baud_clk),
        .rst_n          (rst_n),
        .push_i         (push_s),
        .push_data_i    (rx_data),
        .pop_i          (out_if.out_ready),
        .clr_overflow_i (clr_overflow),
        .rd_data_o      (out_if.out_data),
        .valid_o        (out_if.out_valid),
        .count_o        (count),
        .overflow_o     (overflow)
    );

    assign err_count = err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frame qualification, FIFO ordering,
// full/overflow corner cases, mid-frame reset and error saturation.
module tb_uart_rx_fifo;

    logic       baud_clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_busy;
    logic [4:0] count;
    logic       overflow;
    logic       clr_overflow;
    logic [7:0] err_count;
    int         n_checks;
    int         n_fail;

    uart_rx_fifo_if u_if ();

    uart_rx_fifo u_dut (
        .baud_clk     (baud_clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_busy      (rx_busy),
        .out_if       (u_if),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .err_count    (err_count)
    );

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge baud_clk);
        #1;
    endtask

    // busy high for n edges, then the falling edge carries d
    task automatic send_frame(input logic [7:0] d, input int n, input logic pop, input logic clr);
        rx_busy = 1'b1;
        rx_data = ~d;
        repeat (n) tick();
        rx_busy         = 1'b0;
        rx_data         = d;
        u_if.out_ready  = pop;
        clr_overflow    = clr;
        tick();
        u_if.out_ready  = 1'b0;
        clr_overflow    = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q [$];
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        rx_data        = 8'h00;
        rx_busy        = 1'b0;
        clr_overflow   = 1'b0;
        u_if.out_ready = 1'b0;
        repeat (2) tick();
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_valid", 32'(u_if.out_valid), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_err", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        send_frame(8'hA5, 9, 1'b0, 1'b0);
        check_eq("good_valid", 32'(u_if.out_valid), 32'd1);
        check_eq("good_data", 32'(u_if.out_data), 32'hA5);
        check_eq("good_count", 32'(count), 32'd1);
        check_eq("good_err", 32'(err_count), 32'd0);

        send_frame(8'h3C, 10, 1'b0, 1'b0);
        check_eq("bad_count", 32'(count), 32'd1);
        check_eq("bad_err", 32'(err_count), 32'd1);
        check_eq("bad_head", 32'(u_if.out_data), 32'hA5);

        u_if.out_ready = 1'b1;
        tick();
        check_eq("pop_empty_valid", 32'(u_if.out_valid), 32'd0);
        tick();
        check_eq("pop_while_empty", 32'(count), 32'd0);
        u_if.out_ready = 1'b0;

        for (int i = 0; i < 16; i++) send_frame(8'(i), 9, 1'b0, 1'b0);
        check_eq("fill_count", 32'(count), 32'd16);
        check_eq("fill_ovf", 32'(overflow), 32'd0);
        send_frame(8'hFF, 9, 1'b0, 1'b0);
        check_eq("ovf_count", 32'(count), 32'd16);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        check_eq("ovf_err", 32'(err_count), 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check_eq("ovf_clr", 32'(overflow), 32'd0);

        check_eq("full_head", 32'(u_if.out_data), 32'h00);
        send_frame(8'hEE, 9, 1'b1, 1'b0);
        check_eq("fullpp_count", 32'(count), 32'd16);
        check_eq("fullpp_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'hEE);
        foreach (exp_q[i]) begin
            check_eq($sformatf("drain_%0d", i), 32'(u_if.out_data), 32'(exp_q[i]));
            u_if.out_ready = 1'b1;
            tick();
            u_if.out_ready = 1'b0;
        end
        check_eq("drain_valid", 32'(u_if.out_valid), 32'd0);
        check_eq("drain_count", 32'(count), 32'd0);

        send_frame(8'h11, 9, 1'b0, 1'b0);
        rx_busy = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_count", 32'(count), 32'd0);
        check_eq("mid_rst_valid", 32'(u_if.out_valid), 32'd0);
        check_eq("mid_rst_err", 32'(err_count), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        rx_busy = 1'b0;
        rx_data = 8'h77;
        tick();
        check_eq("unarmed_count", 32'(count), 32'd0);
        check_eq("unarmed_err", 32'(err_count), 32'd0);
        send_frame(8'h5A, 9, 1'b0, 1'b0);
        check_eq("post_rst_count", 32'(count), 32'd1);
        check_eq("post_rst_data", 32'(u_if.out_data), 32'h5A);
        u_if.out_ready = 1'b1;
        tick();
        u_if.out_ready = 1'b0;

        for (int i = 0; i < 254; i++) send_frame(8'h3C, 10, 1'b0, 1'b0);
        check_eq("err_254", 32'(err_count), 32'd254);
        for (int i = 0; i < 6; i++) send_frame(8'h3C, 10, 1'b0, 1'b0);
        check_eq("err_sat", 32'(err_count), 32'd255);
        check_eq("err_no_push", 32'(count), 32'd0);

        for (int i = 0; i < 16; i++) send_frame(8'hC0 + 8'(i), 9, 1'b0, 1'b0);
        check_eq("refill_ovf", 32'(overflow), 32'd0);
        send_frame(8'hFE, 9, 1'b0, 1'b1);
        check_eq("set_beats_clr", 32'(overflow), 32'd1);
        check_eq("refill_count", 32'(count), 32'd16);
        check_eq("refill_head", 32'(u_if.out_data), 32'hC0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
